// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: pipeline controller state encoding and counter width.
package lc3b_types;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } pipe_ctrl_state_t;

   localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Memory handshake bundle between the pipeline controller (master) and the I/D memories (slave).
interface pipe_ctrl_if;
   logic imem_read;
   logic imem_resp;
   logic dmem_read;
   logic dmem_write;
   logic dmem_resp;

   modport master (
      output imem_read,
      output dmem_read,
      output dmem_write,
      input  imem_resp,
      input  dmem_resp
   );

   modport slave (
      input  imem_read,
      input  dmem_read,
      input  dmem_write,
      output imem_resp,
      output dmem_resp
   );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (inc && (count_reg != {WIDTH{1'b1}})) begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;
endmodule

// File: rtl/pipe_ctrl.sv
// LC-3b five-stage pipeline advance controller: memory handshakes, load enables, flushes.
// Optional stall counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import lc3b_types::*;
(
   input  logic             clk,
   input  logic             rst_n,
   pipe_ctrl_if.master      mem,
   input  logic             mem_valid,
   input  logic             mem_rd,
   input  logic             mem_wr,
   input  logic             br_taken,
   input  logic             load_use,
   output logic             load_pc,
   output logic             pc_sel_target,
   output logic             load_if_id,
   output logic             load_id_ex,
   output logic             load_ex_mem,
   output logic             load_mem_wb,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);
   pipe_ctrl_state_t state_reg, state_next;
   logic i_done_reg, i_done_next;
   logic d_done_reg, d_done_next;

   logic active;
   logic d_need;
   logic i_ok;
   logic d_ok;
   logic adv;

   assign active = (state_reg == RUN) || (state_reg == STALL);
   assign d_need = mem_valid & (mem_rd | mem_wr);
   assign i_ok   = i_done_reg | mem.imem_resp;
   assign d_ok   = !d_need | d_done_reg | mem.dmem_resp;
   assign adv    = active & i_ok & d_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= INIT;
         i_done_reg <= 1'b0;
         d_done_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         i_done_reg <= i_done_next;
         d_done_reg <= d_done_next;
      end
   end

   // Flags only accumulate within a stalled window; any advance opens a fresh one.
   always_comb begin
      state_next  = state_reg;
      i_done_next = i_done_reg;
      d_done_next = d_done_reg;
      case (state_reg)
         INIT: begin
            state_next  = RUN;
            i_done_next = 1'b0;
            d_done_next = 1'b0;
         end
         RUN, STALL: begin
            if (adv) begin
               state_next  = RUN;
               i_done_next = 1'b0;
               d_done_next = 1'b0;
            end else begin
               state_next  = STALL;
               i_done_next = i_done_reg | mem.imem_resp;
               d_done_next = d_done_reg | (d_need & mem.dmem_resp);
            end
         end
         default: begin
            state_next  = INIT;
            i_done_next = 1'b0;
            d_done_next = 1'b0;
         end
      endcase
   end

   always_comb begin
      mem.imem_read  = active & !i_done_reg;
      mem.dmem_read  = active & mem_valid & mem_rd & !d_done_reg;
      mem.dmem_write = active & mem_valid & mem_wr & !d_done_reg;
      load_pc        = 1'b0;
      pc_sel_target  = 1'b0;
      load_if_id     = 1'b0;
      load_id_ex     = 1'b0;
      load_ex_mem    = 1'b0;
      load_mem_wb    = 1'b0;
      flush_if_id    = 1'b0;
      flush_id_ex    = 1'b0;
      flush_ex_mem   = 1'b0;
      if (adv) begin
         load_pc     = 1'b1;
         load_if_id  = 1'b1;
         load_id_ex  = 1'b1;
         load_ex_mem = 1'b1;
         load_mem_wb = 1'b1;
         if (br_taken) begin
            pc_sel_target = 1'b1;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            flush_ex_mem  = 1'b1;
         end else if (load_use) begin
            // Hold PC and IF/ID so the dependent instruction is refetched behind a bubble.
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            flush_id_ex = 1'b1;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic stall_inc;

   assign stall_inc = active & (!adv | (load_use & !br_taken));

   sat_counter #(
      .WIDTH(STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .count (stall_cycles)
   );
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; output vector order is
// {imem_read, dmem_read, dmem_write, load_pc, pc_sel_target, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem}.
module tb_pipe_ctrl;
   logic clk;
   logic rst_n;
   logic mem_valid, mem_rd, mem_wr, br_taken, load_use;
   logic load_pc, pc_sel_target;
   logic load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic flush_if_id, flush_id_ex, flush_ex_mem;
`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] stall_cycles;
`endif

   int tests;
   int fails;

   pipe_ctrl_if bus ();

   pipe_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem           (bus),
      .mem_valid     (mem_valid),
      .mem_rd        (mem_rd),
      .mem_wr        (mem_wr),
      .br_taken      (br_taken),
      .load_use      (load_use),
      .load_pc       (load_pc),
      .pc_sel_target (pc_sel_target),
      .load_if_id    (load_if_id),
      .load_id_ex    (load_id_ex),
      .load_ex_mem   (load_ex_mem),
      .load_mem_wb   (load_mem_wb),
      .flush_if_id   (flush_if_id),
      .flush_id_ex   (flush_id_ex),
      .flush_ex_mem  (flush_ex_mem)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cycles  (stall_cycles)
`endif
   );

   logic [11:0] outs;
   assign outs = {bus.imem_read, bus.dmem_read, bus.dmem_write, load_pc, pc_sel_target,
                  load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
      $display("[TB] %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] exp);
`ifdef PIPE_CTRL_PERF_EN
      chk(tag, stall_cycles, exp);
`else
      if (exp == 16'hFFFF) $display("[TB] %s skipped", tag);
`endif
   endtask

   // Advance through one rising edge and land on the next falling edge.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   localparam logic [11:0] ZERO    = 12'b000000000000;
   localparam logic [11:0] ADV_I   = 12'b100101111000;
   localparam logic [11:0] WAIT_I  = 12'b100000000000;

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      br_taken = 1'b0; load_use = 1'b0;
      bus.imem_resp = 1'b0; bus.dmem_resp = 1'b0;
      repeat (3) next_cycle();

      // Reset, then zero-wait fetch release.
      #1 chk("reset_outs", {4'b0, outs}, {4'b0, ZERO});
      chk_cnt("reset_cnt", 16'd0);
      bus.imem_resp = 1'b1;
      rst_n = 1'b1;
      #1 chk("init_outs", {4'b0, outs}, {4'b0, ZERO});
      next_cycle();
      #1 chk("run1_adv", {4'b0, outs}, {4'b0, ADV_I});
      next_cycle();
      #1 chk("run2_adv", {4'b0, outs}, {4'b0, ADV_I});
      next_cycle();

      // Instruction response three cycles late.
      bus.imem_resp = 1'b0;
      #1 chk("iwait1", {4'b0, outs}, {4'b0, WAIT_I});
      next_cycle();
      #1 chk("iwait2", {4'b0, outs}, {4'b0, WAIT_I});
      next_cycle();
      #1 chk("iwait3", {4'b0, outs}, {4'b0, WAIT_I});
      next_cycle();
      bus.imem_resp = 1'b1;
      #1 chk("iresp_adv", {4'b0, outs}, {4'b0, ADV_I});
      next_cycle();
      chk_cnt("cnt_after_iwait", 16'd3);

      // I response at cycle 2, D read response at cycle 5.
      bus.imem_resp = 1'b0;
      mem_valid = 1'b1; mem_rd = 1'b1;
      #1 chk("id_c1", {4'b0, outs}, {4'b0, 12'b110000000000});
      next_cycle();
      bus.imem_resp = 1'b1;
      #1 chk("id_c2_iresp", {4'b0, outs}, {4'b0, 12'b110000000000});
      next_cycle();
      bus.imem_resp = 1'b0;
      #1 chk("id_c3_idrop", {4'b0, outs}, {4'b0, 12'b010000000000});
      next_cycle();
      #1 chk("id_c4", {4'b0, outs}, {4'b0, 12'b010000000000});
      next_cycle();
      bus.dmem_resp = 1'b1;
      #1 chk("id_c5_adv", {4'b0, outs}, {4'b0, 12'b010101111000});
      next_cycle();
      bus.dmem_resp = 1'b0;
      mem_valid = 1'b0; mem_rd = 1'b0;
      bus.imem_resp = 1'b1;
      #1 chk("id_after_clear", {4'b0, outs}, {4'b0, ADV_I});
      chk_cnt("cnt_after_id", 16'd7);
      next_cycle();

      // Taken branch dominates load-use.
      br_taken = 1'b1; load_use = 1'b1;
      #1 chk("branch_luse", {4'b0, outs}, {4'b0, 12'b100111111111});
      next_cycle();
      chk_cnt("cnt_after_branch", 16'd7);

      // Load-use bubble alone.
      br_taken = 1'b0;
      #1 chk("load_use", {4'b0, outs}, {4'b0, 12'b100000111010});
      next_cycle();
      load_use = 1'b0;
      #1 chk("after_luse", {4'b0, outs}, {4'b0, ADV_I});
      chk_cnt("cnt_after_luse", 16'd8);
      next_cycle();

      // Repeated imem_resp while i_done is set is ignored; write stays pending.
      mem_valid = 1'b1; mem_wr = 1'b1;
      #1 chk("wr_c1", {4'b0, outs}, {4'b0, 12'b101000000000});
      next_cycle();
      #1 chk("wr_c2_idone", {4'b0, outs}, {4'b0, 12'b001000000000});
      #2 rst_n = 1'b0;
      #1 chk("async_rst", {4'b0, outs}, {4'b0, ZERO});
      chk_cnt("cnt_async_rst", 16'd0);
      next_cycle();
      bus.imem_resp = 1'b0;
      rst_n = 1'b1;
      #1 chk("rst_init", {4'b0, outs}, {4'b0, ZERO});
      next_cycle();
      #1 chk("rst_run_wr", {4'b0, outs}, {4'b0, 12'b101000000000});
      bus.imem_resp = 1'b1; bus.dmem_resp = 1'b1;
      #1 chk("wr_adv", {4'b0, outs}, {4'b0, 12'b101101111000});
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
